// File: rtl/spi_master_arb_if.sv
// spi_master_arb_if: bundles the two-requester handshake and the SPI pins of spi_master_arb.
//   master modport - seen by the arbiter/SPI engine (requests in, grants/SPI pins out)
//   slave modport  - seen by the requesters and the SPI slave (opposite directions)
// Signals:
//   req[1:0]      level request per requester
//   sel0/sel1     target slave index for requester 0/1
//   tx0/tx1       byte to send for requester 0/1
//   gnt[1:0]      one-cycle one-hot grant pulse
//   done[1:0]     one-cycle completion pulse to the granted requester
//   rx_data       last received byte
//   busy          engine not idle
//   sclk/cs_n/mosi/miso  SPI mode-0 bus
interface spi_master_arb_if;
   logic [1:0] req;
   logic [1:0] sel0;
   logic [1:0] sel1;
   logic [7:0] tx0;
   logic [7:0] tx1;
   logic [1:0] gnt;
   logic [1:0] done;
   logic [7:0] rx_data;
   logic       busy;
   logic       sclk;
   logic [3:0] cs_n;
   logic       mosi;
   logic       miso;

   modport master (
      input  req, sel0, sel1, tx0, tx1, miso,
      output gnt, done, rx_data, busy, sclk, cs_n, mosi
   );

   modport slave (
      output req, sel0, sel1, tx0, tx1, miso,
      input  gnt, done, rx_data, busy, sclk, cs_n, mosi
   );
endinterface

// File: rtl/spi_master_arb.sv
// spi_master_arb: round-robin arbiter for two requesters in front of a single SPI mode-0 master.
// A granted requester's sel/tx are captured at grant time, one byte is shifted MSB first on
// mosi while miso is shifted in, and done pulses back to the winner.
// Ports:
//   clk     system clock, rising-edge
//   rst_n   asynchronous active-low reset
//   io_bus  spi_master_arb_if.master (requests, grants, completion, SPI pins)
// Parameter:
//   CLK_DIV SCLK half-period in clk cycles (1..255)
module spi_master_arb #(
   parameter int unsigned CLK_DIV = 4
) (
   input logic              clk,
   input logic              rst_n,
   spi_master_arb_if.master io_bus
);

   localparam logic [7:0] HalfReload = 8'(CLK_DIV - 1);

   typedef enum logic [1:0] {StIdle, StSetup, StXfer, StDone} state_e;

   state_e     r_state;
   state_e     w_state_next;

   logic [7:0] r_half;
   logic [2:0] r_bit;
   logic       r_sclk;
   logic [7:0] r_tx_sh;
   logic [7:0] r_rx_sh;
   logic [7:0] r_rx_data;
   logic [1:0] r_sel;
   logic       r_win;
   logic       r_last;
   logic [1:0] r_gnt;

   logic       w_half_end;
   logic       w_last_bit;
   logic       w_win;
   logic [3:0] w_cs_n;

   assign w_half_end = (r_half == 8'd0);
   assign w_last_bit = (r_bit == 3'd7);

   // Requester 1 wins when it is alone, or on a tie when requester 0 was granted last.
   assign w_win = io_bus.req[1] & (~io_bus.req[0] | ~r_last);

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (|io_bus.req) begin
               w_state_next = StSetup;
            end
         end
         StSetup: begin
            if (w_half_end) begin
               w_state_next = StXfer;
            end
         end
         StXfer: begin
            // End of the low half of bit 8
            if (w_half_end && !r_sclk && w_last_bit) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            w_state_next = StIdle;
         end
         default: begin
            w_state_next = StIdle;
         end
      endcase
   end

   // Datapath: capture at grant, SCLK generation, shift registers, round-robin pointer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_half    <= 8'd0;
         r_bit     <= 3'd0;
         r_sclk    <= 1'b0;
         r_tx_sh   <= 8'h00;
         r_rx_sh   <= 8'h00;
         r_rx_data <= 8'h00;
         r_sel     <= 2'd0;
         r_win     <= 1'b0;
         r_last    <= 1'b1;
         r_gnt     <= 2'b00;
      end else begin
         r_gnt <= 2'b00;
         unique case (r_state)
            StIdle: begin
               if (|io_bus.req) begin
                  r_gnt   <= w_win ? 2'b10 : 2'b01;
                  r_win   <= w_win;
                  r_sel   <= w_win ? io_bus.sel1 : io_bus.sel0;
                  r_tx_sh <= w_win ? io_bus.tx1 : io_bus.tx0;
                  r_half  <= HalfReload;
                  r_bit   <= 3'd0;
                  r_sclk  <= 1'b0;
               end
            end
            StSetup: begin
               if (w_half_end) begin
                  // First SCLK rise: sample bit 1 of miso
                  r_sclk  <= 1'b1;
                  r_half  <= HalfReload;
                  r_rx_sh <= {r_rx_sh[6:0], io_bus.miso};
               end else begin
                  r_half <= r_half - 8'd1;
               end
            end
            StXfer: begin
               if (!w_half_end) begin
                  r_half <= r_half - 8'd1;
               end else if (r_sclk) begin
                  // Falling edge: present the next bit unless bit 8 just went out
                  r_sclk <= 1'b0;
                  r_half <= HalfReload;
                  if (!w_last_bit) begin
                     r_tx_sh <= {r_tx_sh[6:0], 1'b0};
                  end
               end else if (w_last_bit) begin
                  r_half    <= 8'd0;
                  r_rx_data <= r_rx_sh;
               end else begin
                  r_sclk  <= 1'b1;
                  r_half  <= HalfReload;
                  r_bit   <= r_bit + 3'd1;
                  r_rx_sh <= {r_rx_sh[6:0], io_bus.miso};
               end
            end
            StDone: begin
               r_last  <= r_win;
               r_tx_sh <= 8'h00;
            end
            default: begin
               r_gnt <= 2'b00;
            end
         endcase
      end
   end

   // Output logic
   always_comb begin
      w_cs_n = 4'b1111;
      if (r_state == StSetup || r_state == StXfer) begin
         w_cs_n[r_sel] = 1'b0;
      end
   end

   always_comb begin
      io_bus.busy    = (r_state != StIdle);
      io_bus.cs_n    = w_cs_n;
      io_bus.sclk    = r_sclk;
      io_bus.mosi    = r_tx_sh[7];
      io_bus.gnt     = r_gnt;
      io_bus.rx_data = r_rx_data;
      io_bus.done    = 2'b00;
      if (r_state == StDone) begin
         io_bus.done = r_win ? 2'b10 : 2'b01;
      end
   end

endmodule

// File: doc/spi_master_arb.md
SPI_MASTER_ARB -- requirements
Module: spi_master_arb

Interface
REQ-001 Parameter CLK_DIV, default 4, SCLK half-period in clk cycles; legal range 1..255.
REQ-002 clk  input  1  system clock; all state changes on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 req  input  2  per-requester transfer request, level, bit i = requester i.
REQ-005 sel0, sel1  input  2 each  target slave index (0..3) for requester 0/1.
REQ-006 tx0, tx1  input  8 each  byte to send for requester 0/1.
REQ-007 gnt  output  2  one-cycle grant pulse, one-hot; sel/tx of the granted requester are captured that cycle.
REQ-008 done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 rx_data  output  8  byte received from MISO, valid from done pulse until next done.
REQ-010 busy  output  1  high in every state except IDLE.
REQ-011 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-012 cs_n  output  4  active-low chip selects, at most one low.
REQ-013 mosi  output  1  serial data out, MSB first.
REQ-014 miso  input  1  serial data in; may be high-Z while all cs_n high.

Function
REQ-015 FSM states: IDLE, SETUP, XFER, DONE.
REQ-016 IDLE: if any req bit high, SHALL select winner, go to SETUP next edge; else stay.
REQ-017 Arbitration round-robin: single request wins; both high -> requester other than last-granted wins; last-granted resets to 1 (requester 0 wins first tie).
REQ-018 Entering SETUP: gnt[winner]=1 for exactly that first SETUP cycle; tx byte and sel latched; cs_n[sel] driven low; mosi = tx[7]; sclk=0.
REQ-019 SETUP lasts CLK_DIV cycles, then XFER.
REQ-020 XFER: 8 bits; per bit sclk high CLK_DIV cycles then low CLK_DIV cycles.
REQ-021 On each sclk rising transition, miso SHALL be sampled and shifted into rx shift register LSB (MSB first received).
REQ-022 On each sclk falling transition except after bit 8, mosi SHALL advance to next lower tx bit.
REQ-023 After low half of bit 8, go to DONE; cs_n low total = 17*CLK_DIV cycles.
REQ-024 DONE (one cycle): all cs_n high, sclk 0, done[winner]=1, rx_data updated with received byte, update last-granted; then IDLE.
REQ-025 Minimum one IDLE cycle (cs_n all high) between transactions, even with req held high.
REQ-026 req, sel, tx changes after grant SHALL be ignored until DONE; req deassert mid-transfer does not abort.
REQ-027 Held-high req issues a new transaction per IDLE visit; requester must drop req after done to avoid repeat.
REQ-028 Bit counter 3-bit, half-period counter 8-bit; counter reload to CLK_DIV-1, no wrap other than reload.

Reset
REQ-029 rst_n low SHALL immediately force: state IDLE, cs_n=4'b1111, sclk=0, mosi=0, gnt=0, done=0, busy=0, rx_data=8'h00, last-granted=1, counters 0.
REQ-030 Reset mid-transfer aborts silently: no done pulse, rx_data=0, cs_n high asynchronously.
REQ-031 After rst_n rises, first arbitration occurs on first clk edge with req sampled high.

Verification
REQ-032 CLK_DIV=4, req=01, sel0=2, tx0=8'hA5, slave returns 8'h3C -> gnt=01, cs_n=1011 for 68 cycles, mosi bits 1,0,1,0,0,1,0,1 on rising edges, done=01, rx_data=8'h3C.
REQ-033 req=11 held from reset, tx0=8'h11, tx1=8'h22 -> grant order 0,1,0,1; exactly one idle cycle with cs_n=1111 between transfers.
REQ-034 CLK_DIV=1, req=10, sel1=3, tx1=8'hFF, miso=0 -> sclk period 2 clk, cs_n=0111 for 17 cycles, rx_data=8'h00, done=10.
REQ-035 rst_n low at bit 4 of transfer -> cs_n=1111, sclk=0 without clk edge; no done; after release next req granted to requester 0 on tie.
REQ-036 Change tx0 and sel0 and drop req[0] during XFER -> transferred byte and cs_n line unchanged from grant values; done still pulses.
